ir_queue: RTL and testbench

//  Parametrised instruction register with a DEPTH-entry prefetch queue for the t5-style accumulator CPU.
//  The block accepts fetched instruction words over a valid/ready handshake and buffers them in FIFO order.
//  It decodes the head entry into op/ad for the control unit.
//  A flush drops all queued words on a jump/taken branch, so the CU never executes stale prefetches.

---
 rtl/ir_queue_pkg.sv | 26 ++
 rtl/ir_decode.sv | 34 +++
 rtl/ir_queue.sv | 106 ++++++++++
 tb/tb_ir_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ir_queue_pkg.sv
// rtl/ir_queue_pkg.sv - cu_* opcode defines and shared defaults for the instruction prefetch queue
`ifndef IR_DEFS_VH
`define IR_DEFS_VH
`define CU_LDA        3'b000
`define CU_ADD        3'b001
`define CU_STA        3'b010
`define CU_BAN        3'b011
`define CU_JMP        3'b100
`define CU_LONG_BEGIN 3'b111
`define CU_CSL        5'b00001
`define CU_SHR        5'b00010
`define CU_COM        5'b00100
`define CU_CLA        5'b01000
`define CU_STOP       5'b10000
`endif

package ir_queue_pkg;
  localparam int DEF_IW    = 8;
  localparam int DEF_OPW   = 3;
  localparam int DEF_DEPTH = 4;
  localparam logic [2:0] DEF_LONG_CODE = `CU_LONG_BEGIN;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/ir_decode.sv
// rtl/ir_decode.sv - combinational head-word decode into op/ad/is_long
module ir_decode #(
  parameter int IW = 8,
  parameter int OPW = 3,
  parameter logic [OPW-1:0] LONG_CODE = '1
) (
  input  logic          valid_i,
  input  logic [IW-1:0] instr_i,
  output logic [IW-1:0] op_o,
  output logic [IW-1:0] ad_o,
  output logic          is_long_o
);
  logic [OPW-1:0]    opc;
  logic [IW-OPW-1:0] operand;

  assign opc     = instr_i[IW-1 -: OPW];
  assign operand = instr_i[IW-OPW-1:0];

  // Empty queue must decode to all zeros no matter what the stale RAM holds.
  always_comb begin
    op_o      = '0;
    ad_o      = '0;
    is_long_o = 1'b0;
    if (valid_i) begin
      if (opc == LONG_CODE) begin
        op_o      = {1'b1, {(OPW-1){1'b0}}, operand};
        is_long_o = 1'b1;
      end else begin
        op_o = {{(IW-OPW){1'b0}}, opc};
        ad_o = {{OPW{1'b0}}, operand};
      end
    end
  end
endmodule

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - instruction register with DEPTH-entry prefetch queue and flush
// Optional IR_PARITY_EN: per-entry parity bit (in_par) checked at the head (perr).
module ir_queue
  import ir_queue_pkg::*;
#(
  parameter int IW = DEF_IW,
  parameter int OPW = DEF_OPW,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [OPW-1:0] LONG_CODE = OPW'(DEF_LONG_CODE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IW-1:0]              in_data,
`ifdef IR_PARITY_EN
  input  logic                       in_par,
  output logic                       perr,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IW-1:0]              op,
  output logic [IW-1:0]              ad,
  output logic                       is_long,
  output logic [cnt_w(DEPTH)-1:0]    count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
`ifdef IR_PARITY_EN
  localparam int EW = IW + 1;
`else
  localparam int EW = IW;
`endif

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [EW-1:0] wr_entry, head_entry;

`ifdef IR_PARITY_EN
  assign wr_entry = {in_par, in_data};
`else
  assign wr_entry = in_data;
`endif

  assign in_ready   = (count_q < CW'(DEPTH));
  assign out_valid  = (count_q != '0);
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign count      = count_q;
  assign head_entry = mem_q[rd_ptr_q];

  // Flush wins over both handshakes; DEPTH is a power of two so pointers wrap for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_entry;
  end

  ir_decode #(
    .IW(IW),
    .OPW(OPW),
    .LONG_CODE(LONG_CODE)
  ) u_decode (
    .valid_i  (out_valid),
    .instr_i  (head_entry[IW-1:0]),
    .op_o     (op),
    .ad_o     (ad),
    .is_long_o(is_long)
  );

`ifdef IR_PARITY_EN
  assign perr = out_valid & (^head_entry);
`endif
endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - directed self-checking bench for ir_queue
module tb_ir_queue;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
`ifdef IR_PARITY_EN
  logic       in_par = 1'b0;
  logic       perr;
`endif
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] op, ad;
  logic       is_long;
  logic [2:0] count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ir_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef IR_PARITY_EN
    .in_par(in_par), .perr(perr),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .ad(ad), .is_long(is_long), .count(count)
  );

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (out_valid === 1'b1 && n < 12) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("drain_empty", {7'b0, out_valid}, 8'h00);
  endtask

  task automatic test_reset();
    chk("rst_count", {5'b0, count}, 8'h00);
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_in_ready", {7'b0, in_ready}, 8'h01);
    chk("rst_op", op, 8'h00);
    chk("rst_ad", ad, 8'h00);
    chk("rst_is_long", {7'b0, is_long}, 8'h00);
    rst = 1'b0;
    tick();
    push_word(8'h21);
    push_word(8'h42);
    push_word(8'h63);
    chk("pre_rst_count", {5'b0, count}, 8'h03);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", {5'b0, count}, 8'h00);
    chk("async_rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("async_rst_op", op, 8'h00);
    chk("async_rst_ad", ad, 8'h00);
    chk("async_rst_in_ready", {7'b0, in_ready}, 8'h01);
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_decode();
    push_word(8'h21);
    chk("dec21_valid", {7'b0, out_valid}, 8'h01);
    chk("dec21_op", op, 8'h01);
    chk("dec21_ad", ad, 8'h01);
    chk("dec21_long", {7'b0, is_long}, 8'h00);
    drain();
    push_word(8'hE3);
    chk("decE3_op", op, 8'h83);
    chk("decE3_ad", ad, 8'h00);
    chk("decE3_long", {7'b0, is_long}, 8'h01);
    drain();
    chk("empty_op", op, 8'h00);
    chk("empty_long", {7'b0, is_long}, 8'h00);
  endtask

  task automatic test_fill();
    logic [7:0] words [4] = '{8'h21, 8'h42, 8'h63, 8'h84};
    logic [7:0] e_op  [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] e_ad  [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) push_word(words[i]);
    chk("full_count", {5'b0, count}, 8'h04);
    chk("full_in_ready", {7'b0, in_ready}, 8'h00);
    push_word(8'hA5);
    chk("full_push_ignored", {5'b0, count}, 8'h04);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_valid%0d", i), {7'b0, out_valid}, 8'h01);
      chk($sformatf("fill_op%0d", i), op, e_op[i]);
      chk($sformatf("fill_ad%0d", i), ad, e_ad[i]);
      tick();
    end
    chk("fill_empty", {7'b0, out_valid}, 8'h00);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back(input int n);
    logic [7:0] q[$];
    logic [7:0] next = 8'h30;
    for (int i = 0; i < n; i++) begin
      push_word(next);
      q.push_back(next);
      next = next + 8'd9;
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = next;
      chk($sformatf("b2b%0d_count%0d", n, c), {5'b0, count}, 8'(n));
      chk($sformatf("b2b%0d_op%0d", n, c), op, {5'b0, q[0][7:5]});
      chk($sformatf("b2b%0d_ad%0d", n, c), ad, {3'b0, q[0][4:0]});
      tick();
      void'(q.pop_front());
      q.push_back(next);
      next = next + 8'd9;
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_flush();
    push_word(8'h21);
    push_word(8'h42);
    push_word(8'h63);
    chk("pre_flush_count", {5'b0, count}, 8'h03);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hE5;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", {5'b0, count}, 8'h00);
    chk("flush_out_valid", {7'b0, out_valid}, 8'h00);
    chk("flush_is_long", {7'b0, is_long}, 8'h00);
    push_word(8'h84);
    chk("post_flush_count", {5'b0, count}, 8'h01);
    chk("post_flush_op", op, 8'h04);
    chk("post_flush_ad", ad, 8'h04);
    drain();
  endtask

  task automatic test_pop_empty();
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    chk("pop_empty_count", {5'b0, count}, 8'h00);
    push_word(8'h42);
    chk("pop_empty_head", ad, 8'h02);
    drain();
  endtask

`ifdef IR_PARITY_EN
  task automatic test_parity();
    chk("perr_empty", {7'b0, perr}, 8'h00);
    in_par = 1'b1;
    push_word(8'h21);
    chk("perr_odd", {7'b0, perr}, 8'h01);
    drain();
    in_par = 1'b0;
    push_word(8'h21);
    chk("perr_even", {7'b0, perr}, 8'h00);
    drain();
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_decode();
    test_fill();
    test_back_to_back(2);
    test_back_to_back(1);
    test_back_to_back(3);
    test_flush();
    test_pop_empty();
`ifdef IR_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
